// File: rtl/phase_gen.sv
// Phase generator: divides clk by a programmable divisor and steps an
// Q_W-bit phase quotient that drives a waveshaper. New divisors taken while
// running are held back until the phase wraps so a period is never split.
module phase_gen #(
   parameter int DIV_W = 16,
   parameter int Q_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             note_on,
   input  logic [DIV_W-1:0] divisor,
   input  logic             div_load,
   output logic [Q_W-1:0]   quotient,
   output logic             step,
   output logic             wrap,
   output logic             pending
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [Q_W-1:0]   Q_MAX   = '1;
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;          // cycles elapsed in current step
   logic [DIV_W-1:0] div_q, div_d;          // active divisor
   logic [DIV_W-1:0] pend_div_q, pend_div_d;// divisor waiting for a wrap
   logic             pend_q, pend_d;
   logic [Q_W-1:0]   quot_q, quot_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;

   logic             stepping;
   logic             at_top;

   // Next-state logic for the oscillator, divisor handoff and output pulses.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_div_d = pend_div_q;
      pend_d     = pend_q;
      quot_d     = quot_q;
      step_d     = 1'b0;
      wrap_d     = 1'b0;
      stepping   = 1'b0;
      at_top     = (quot_q == Q_MAX);

      if (!en) begin
         // Disable wins over everything: drop to IDLE and forget any
         // divisor that was still waiting for a wrap.
         state_d    = IDLE;
         cnt_d      = '0;
         quot_d     = '0;
         pend_d     = 1'b0;
         pend_div_d = '0;
         if (div_load) begin
            div_d = divisor;
         end
      end else if (state_q == IDLE) begin
         // Nothing is playing yet, so a load can take effect directly.
         state_d = RUN;
         cnt_d   = '0;
         quot_d  = '0;
         pend_d  = 1'b0;
         if (div_load) begin
            div_d = divisor;
         end
      end else if (note_on) begin
         // Restart the phase; a fresh note is a safe point to switch pitch.
         cnt_d  = '0;
         quot_d = '0;
         pend_d = 1'b0;
         if (div_load) begin
            div_d = divisor;
         end else if (pend_q) begin
            div_d = pend_div_q;
         end
      end else begin
         // Divisor 0 is silence: counter and phase simply hold.
         stepping = (div_q != '0) && (cnt_q >= div_q - DIV_ONE);
         if (stepping) begin
            cnt_d  = '0;
            quot_d = quot_q + Q_W'(1);
            step_d = 1'b1;
            wrap_d = at_top;
         end else if (div_q != '0) begin
            cnt_d = cnt_q + DIV_ONE;
         end

         if (stepping && at_top) begin
            // Period boundary: swap in the newest divisor available.
            if (div_load) begin
               div_d  = divisor;
               pend_d = 1'b0;
            end else if (pend_q) begin
               div_d  = pend_div_q;
               pend_d = 1'b0;
            end
         end else if (div_load) begin
            pend_div_d = divisor;
            pend_d     = 1'b1;
         end
      end
   end

   // State, counters and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         pend_div_q <= '0;
         pend_q     <= 1'b0;
         quot_q     <= '0;
         step_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of the others, independent of statement order.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_div_q <= pend_div_d;
         pend_q     <= pend_d;
         quot_q     <= quot_d;
         step_q     <= step_d;
         wrap_q     <= wrap_d;
      end
   end

   assign quotient = quot_q;
   assign step     = step_q;
   assign wrap     = wrap_q;
   assign pending  = pend_q;

endmodule

// File: tb/tb_phase_gen.sv
// Self-checking bench for phase_gen: directed scenarios followed by random
// stimulus, all compared every cycle against a step-counting reference model.
module tb_phase_gen;

   localparam int DIV_W = 16;
   localparam int Q_W   = 8;
   localparam int Q_N   = 1 << Q_W;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             note_on;
   logic [DIV_W-1:0] divisor;
   logic             div_load;
   logic [Q_W-1:0]   quotient;
   logic             step;
   logic             wrap;
   logic             pending;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the phase is "cycles since the period started divided
   // by the divisor"; a new period starts on run entry, note_on and wrap.
   bit m_run;
   bit m_pend;
   int m_d;
   int m_pdiv;
   int m_t;
   bit m_step;
   bit m_wrap;

   phase_gen #(.DIV_W(DIV_W), .Q_W(Q_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .note_on  (note_on),
      .divisor  (divisor),
      .div_load (div_load),
      .quotient (quotient),
      .step     (step),
      .wrap     (wrap),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_quot();
      return (m_d > 0) ? (m_t / m_d) : 0;
   endfunction

   task automatic model_reset();
      m_run  = 1'b0;
      m_pend = 1'b0;
      m_d    = 0;
      m_pdiv = 0;
      m_t    = 0;
      m_step = 1'b0;
      m_wrap = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs presented to it.
   task automatic model_edge();
      m_step = 1'b0;
      m_wrap = 1'b0;
      if (rst) begin
         model_reset();
      end else if (!en) begin
         m_run  = 1'b0;
         m_t    = 0;
         m_pend = 1'b0;
         if (div_load) m_d = int'(divisor);
      end else if (!m_run) begin
         m_run  = 1'b1;
         m_t    = 0;
         m_pend = 1'b0;
         if (div_load) m_d = int'(divisor);
      end else if (note_on) begin
         m_t = 0;
         if (div_load) m_d = int'(divisor);
         else if (m_pend) m_d = m_pdiv;
         m_pend = 1'b0;
      end else begin
         if (m_d > 0) begin
            m_t++;
            m_step = (m_t % m_d) == 0;
            m_wrap = (m_t == Q_N * m_d);
         end
         if (m_wrap) begin
            m_t = 0;
            if (div_load) begin
               m_d    = int'(divisor);
               m_pend = 1'b0;
            end else if (m_pend) begin
               m_d    = m_pdiv;
               m_pend = 1'b0;
            end
         end else if (div_load) begin
            m_pdiv = int'(divisor);
            m_pend = 1'b1;
         end
      end
   endtask

   // One clock: update the model on the edge, compare just after it.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("quotient", 32'(quotient), 32'(m_quot()));
      check("step",     32'(step),     32'(m_step));
      check("wrap",     32'(wrap),     32'(m_wrap));
      check("pending",  32'(pending),  32'(m_pend));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load(input int val);
      divisor  = DIV_W'(val);
      div_load = 1'b1;
      tick();
      div_load = 1'b0;
   endtask

   task automatic strike();
      note_on = 1'b1;
      tick();
      note_on = 1'b0;
   endtask

   task automatic run_until_q(input int target, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (m_quot() == target) return;
         tick();
      end
      n_checks++;
      n_fail++;
      $display("FAIL timeout: quotient never reached %0d within %0d cycles", target, limit);
   endtask

   initial begin
      rst      = 1'b0;
      en       = 1'b0;
      note_on  = 1'b0;
      div_load = 1'b0;
      divisor  = '0;
      model_reset();
      #1 rst = 1'b1;
      #1;
      check("reset_quotient", 32'(quotient), 32'd0);
      check("reset_step",     32'(step),     32'd0);
      check("reset_wrap",     32'(wrap),     32'd0);
      check("reset_pending",  32'(pending),  32'd0);
      cycles(2);
      rst = 1'b0;
      cycles(2);

      // Divide by 4 from IDLE, run through a full wrap.
      load(4);
      check("idle_load_no_pending", 32'(pending), 32'd0);
      en = 1'b1;
      cycles(1100);

      // Divisor change mid-period waits for the wrap.
      run_until_q(10, 2000);
      load(2);
      check("run_load_pending", 32'(pending), 32'd1);
      cycles(1100);

      // note_on restarts the phase at 0 and applies D=3 right away.
      load(3);
      strike();
      run_until_q(100, 1000);
      strike();
      check("note_on_q0",    32'(quotient), 32'd0);
      check("note_on_nostep", 32'(step),    32'd0);
      cycles(3);
      check("note_on_first_q",    32'(quotient), 32'd1);
      check("note_on_first_step", 32'(step),     32'd1);
      cycles(10);

      // Divisor 0 is silence; a pending divisor waits for note_on.
      en = 1'b0;
      tick();
      load(0);
      en = 1'b1;
      cycles(500);
      check("silence_q", 32'(quotient), 32'd0);
      load(1);
      cycles(20);
      check("silence_pending", 32'(pending), 32'd1);
      strike();
      cycles(10);

      // Disable with a pending divisor discards it.
      load(2);
      strike();
      run_until_q(50, 500);
      load(3);
      en = 1'b0;
      tick();
      check("disable_q",       32'(quotient), 32'd0);
      check("disable_pending", 32'(pending),  32'd0);
      en = 1'b1;
      cycles(20);

      // Asynchronous reset between edges.
      run_until_q(77, 500);
      #3 rst = 1'b1;
      #1;
      check("async_rst_q",       32'(quotient), 32'd0);
      check("async_rst_step",    32'(step),     32'd0);
      check("async_rst_wrap",    32'(wrap),     32'd0);
      check("async_rst_pending", 32'(pending),  32'd0);
      #1 rst = 1'b0;
      model_reset();
      cycles(30);
      check("post_rst_silent", 32'(quotient), 32'd0);

      // Random stimulus: long stretches so wraps occur, occasional
      // disable, restart and divisor loads with small divisors.
      for (int i = 0; i < 4000; i++) begin
         en       = ($urandom_range(499) != 0);
         note_on  = ($urandom_range(399) == 0);
         div_load = ($urandom_range(99) == 0);
         divisor  = DIV_W'($urandom_range(3));
         tick();
      end
      en       = 1'b1;
      note_on  = 1'b0;
      div_load = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         note_on  = ($urandom_range(29) == 0);
         div_load = ($urandom_range(14) == 0);
         divisor  = DIV_W'($urandom_range(2));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, the width of the divisor and cycle counter.
REQ-002 SHALL have parameter Q_W, default 8, the width of the phase quotient fed to the waveshaper.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1, oscillator enable; low forces IDLE.
REQ-006 SHALL have port note_on, input, 1, single-cycle strobe that restarts the phase at 0.
REQ-007 SHALL have port divisor, input, DIV_W, clock cycles per quotient step.
REQ-008 SHALL have port div_load, input, 1, single-cycle strobe that captures divisor.
REQ-009 SHALL have port quotient, output, Q_W, current phase (0..2^Q_W-1), registered.
REQ-010 SHALL have port step, output, 1, registered pulse, high for exactly the cycle in which quotient first shows a newly stepped value.
REQ-011 SHALL have port wrap, output, 1, registered pulse, high when quotient goes from 2^Q_W-1 to 0 by stepping.
REQ-012 SHALL have port pending, output, 1, high while a captured divisor awaits application.

Function
REQ-013 SHALL implement two states: IDLE and RUN.
REQ-014 IDLE->RUN SHALL occur on the first edge with en=1; RUN->IDLE SHALL occur on any edge with en=0.
REQ-015 In IDLE: quotient=0, cycle counter=0, step=0, wrap=0.
REQ-016 In IDLE, div_load SHALL write divisor directly into the active divisor; pending SHALL stay 0.
REQ-017 In RUN, div_load SHALL write divisor into a pending register and set pending=1; a later div_load before application SHALL overwrite it.
REQ-018 In RUN with active divisor D>=1, the counter SHALL count 0..D-1; at D-1 it SHALL return to 0, quotient SHALL increment modulo 2^Q_W, and step SHALL pulse.
REQ-019 Step period SHALL be exactly D cycles; D=1 SHALL step every cycle.
REQ-020 D=0 SHALL mean silence: counter and quotient held, no step, no wrap.
REQ-021 A pending divisor SHALL become active only at a wrap step, so a waveform period is never split; pending SHALL clear on that same edge.
REQ-022 div_load coinciding with a wrap step SHALL make the newly presented divisor active at that wrap, with pending=0.
REQ-023 note_on in RUN SHALL set quotient=0 and counter=0 on the next edge, apply any pending divisor immediately, clear pending, and suppress step/wrap for that edge.
REQ-024 note_on coinciding with a step condition SHALL take priority (REQ-023).
REQ-025 note_on with en=0 SHALL be ignored; en=0 SHALL take priority over all other inputs.
REQ-026 On RUN->IDLE, a pending divisor SHALL be discarded and pending cleared.
REQ-027 Output latency: quotient/step/wrap SHALL change on the edge after the counter reaches D-1; there are no combinational paths from inputs to outputs.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, quotient=0, counter=0, active divisor=0, pending register=0, step=0, wrap=0, pending=0, regardless of clk.
REQ-029 Reset asserted mid-period SHALL discard all phase and divisor state; after release, the block SHALL require a div_load before stepping.

Verification
REQ-030 Reset, div_load divisor=4 in IDLE, en=1 -> step every 4 cycles; quotient 0,1,2,...; wrap pulses after 256 steps (1024 cycles) with quotient=0.
REQ-031 RUN D=4, div_load divisor=2 at quotient=10 -> pending=1; step spacing stays 4 through quotient 255; from the wrap onward spacing is 2, with pending=0.
REQ-032 RUN D=3, note_on at quotient=100 -> next cycle quotient=0, step=0; next step arrives 3 cycles later with quotient=1.
REQ-033 div_load divisor=0 in IDLE, en=1 -> quotient stays 0 for 500 cycles with no step; div_load divisor=1 then pending=1 and nothing steps (no wrap occurs); note_on -> every cycle steps.
REQ-034 RUN D=2, en dropped at quotient=50 with pending set -> next cycle quotient=0, pending=0, state IDLE; en re-raised -> steps at D=2.
REQ-035 Assert rst between clock edges at quotient=77 -> quotient=0, step=0, wrap=0, pending=0 without waiting for clk.
